// File: rtl/capture_sequencer_pkg.sv
// Shared types for the capture sequencer slice.
package capture_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    READOUT
  } capture_state_t;

endpackage

// File: rtl/capture_sequencer_if.sv
// Readout stream (valid/ready with last) from the capture sequencer to the demodulator.
interface capture_sequencer_if #(
  parameter int unsigned SAMPLE_DATA_WIDTH = 8
) ();

  logic                                axiov;
  logic signed [SAMPLE_DATA_WIDTH-1:0] axiod;
  logic                                axiolast;
  logic                                axioready;

  modport master (output axiov, output axiod, output axiolast, input axioready);
  modport slave  (input axiov, input axiod, input axiolast, output axioready);

endinterface

// File: rtl/capture_sequencer_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module capture_sequencer_sample_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_sequencer.sv
// Ring-buffers samples, freezes a pre/post-trigger window on a trigger edge,
// then streams that window out over a valid/ready interface.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int unsigned SAMPLE_DATA_WIDTH = 8,
  parameter int unsigned CAPTURE_LEN       = 1024,
  parameter int unsigned PRETRIGGER        = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                arm,
  input  logic                                abort,
  input  logic                                axiiv,
  input  logic signed [SAMPLE_DATA_WIDTH-1:0] axiid,
  input  logic                                triggered,
  capture_sequencer_if.master                 rd_if,
  output logic                                busy,
  output logic                                dropped
);

  localparam int unsigned ADDR_WIDTH = $clog2(CAPTURE_LEN);
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam int unsigned POST_LEN   = CAPTURE_LEN - PRETRIGGER;

  typedef logic [ADDR_WIDTH-1:0]               addr_t;
  typedef logic [CNT_WIDTH-1:0]                cnt_t;
  typedef logic signed [SAMPLE_DATA_WIDTH-1:0] sample_t;

  capture_state_t state_q, state_n;

  logic    trig_q, trig_edge;
  addr_t   wr_ptr_q, start_q, rd_ptr_q;
  cnt_t    fill_cnt_q, post_cnt_q, rd_cnt_q;
  logic    wr_en, rd_issue, xfer, post_full;
  logic [1:0] occ;

  logic    pend_q, pend_last_q;
  logic    pf_valid_q, pf_last_q;
  sample_t pf_data_q;
  logic    axiov_q, axiolast_q, busy_q, dropped_q;
  sample_t axiod_q;
  logic [SAMPLE_DATA_WIDTH-1:0] ram_rdata;

  assign trig_edge = triggered & ~trig_q;
  assign xfer      = axiov_q & rd_if.axioready;
  assign post_full = (post_cnt_q == CNT_WIDTH'(POST_LEN));
  // Samples owned by the readout pipe: output register, prefetch slot, read in flight.
  assign occ       = 2'(axiov_q) + 2'(pf_valid_q) + 2'(pend_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    wr_en    = 1'b0;
    rd_issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) state_n = FILL;
      end
      FILL: begin
        wr_en = axiiv;
        if (axiiv && fill_cnt_q == CNT_WIDTH'(PRETRIGGER - 1)) state_n = ARMED;
      end
      ARMED: begin
        wr_en = axiiv;
        if (trig_edge) state_n = POST;
      end
      POST: begin
        wr_en = axiiv & ~post_full;
        if (post_full || (axiiv && post_cnt_q == CNT_WIDTH'(POST_LEN - 1))) state_n = READOUT;
      end
      READOUT: begin
        rd_issue = (rd_cnt_q != CNT_WIDTH'(CAPTURE_LEN)) && ((occ - 2'(xfer)) < 2'd2);
        if (xfer && axiolast_q) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n  = IDLE;
      wr_en    = 1'b0;
      rd_issue = 1'b0;
    end
  end

  // Pointers, counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
      wr_ptr_q   <= '0;
      start_q    <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      post_cnt_q <= '0;
      rd_cnt_q   <= '0;
    end else begin
      trig_q <= triggered;
      busy_q <= (state_n != IDLE);

      if (state_q == IDLE && state_n == FILL) begin
        wr_ptr_q   <= '0;
        fill_cnt_q <= '0;
        dropped_q  <= 1'b0;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end

      if (state_q == FILL && axiiv) fill_cnt_q <= fill_cnt_q + CNT_WIDTH'(1);

      // A sample valid in the edge cycle is the first post-trigger sample.
      if (state_q == ARMED && state_n == POST) begin
        start_q    <= wr_ptr_q - ADDR_WIDTH'(PRETRIGGER);
        post_cnt_q <= CNT_WIDTH'(axiiv);
      end else if (state_q == POST && wr_en) begin
        post_cnt_q <= post_cnt_q + CNT_WIDTH'(1);
      end

      if (state_q == POST && state_n == READOUT) begin
        rd_ptr_q <= start_q;
        rd_cnt_q <= '0;
      end else if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
        rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
      end

      if (state_q == READOUT && axiiv) dropped_q <= 1'b1;
    end
  end

  // Output register fed first from the prefetch slot, then from the RAM read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pf_valid_q  <= 1'b0;
      pf_last_q   <= 1'b0;
      pf_data_q   <= '0;
      axiov_q     <= 1'b0;
      axiolast_q  <= 1'b0;
      axiod_q     <= '0;
    end else if (abort) begin
      pend_q     <= 1'b0;
      pf_valid_q <= 1'b0;
      axiov_q    <= 1'b0;
      axiolast_q <= 1'b0;
    end else begin
      pend_q      <= rd_issue;
      pend_last_q <= rd_issue && (rd_cnt_q == CNT_WIDTH'(CAPTURE_LEN - 1));
      if (!axiov_q || xfer) begin
        if (pf_valid_q) begin
          axiov_q    <= 1'b1;
          axiod_q    <= pf_data_q;
          axiolast_q <= pf_last_q;
          pf_valid_q <= pend_q;
          pf_data_q  <= ram_rdata;
          pf_last_q  <= pend_last_q;
        end else if (pend_q) begin
          axiov_q    <= 1'b1;
          axiod_q    <= ram_rdata;
          axiolast_q <= pend_last_q;
        end else begin
          axiov_q    <= 1'b0;
          axiolast_q <= 1'b0;
        end
      end else if (pend_q) begin
        pf_valid_q <= 1'b1;
        pf_data_q  <= ram_rdata;
        pf_last_q  <= pend_last_q;
      end
    end
  end

  capture_sequencer_sample_ram #(
    .WIDTH (SAMPLE_DATA_WIDTH),
    .DEPTH (CAPTURE_LEN)
  ) u_sample_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (axiid),
    .re    (rd_issue),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign rd_if.axiov    = axiov_q;
  assign rd_if.axiod    = axiod_q;
  assign rd_if.axiolast = axiolast_q;
  assign busy           = busy_q;
  assign dropped        = dropped_q;

endmodule
